data_mem_responder: RTL and testbench
=====================================

# data_mem_responder

Multicycle data-memory responder: the slave end of the control unit's MEM-state access (DataMemRW). Accepts one load/store request at a time, inserts a fixed number of wait states, performs the access on a byte-addressed big-endian array, and signals completion with a one-cycle `ready` pulse. Sits between the control unit/ALU result register and the write-back mux (`ALUM2Reg` path).

## Interface
- `DEPTH_BYTES`, 128: memory size in bytes; power of two, ≥ 4.
- `WAIT_CYCLES`, 1: wait states between acceptance and access; 0..15.

- `clk` input 1: single clock; all logic on rising edge.
- `RST` input 1: reset, synchronous, active-low.
- `req` input 1: request strobe; sampled only in IDLE.
- `DataMemRW` input 1: 1 = write (sw), 0 = read (lw); latched at acceptance.
- `addr` input 32: byte address (ALU result); latched at acceptance.
- `wdata` input 32: store data (rt); latched at acceptance.
- `rdata` output 32: load data; holds last completed read.
- `ready` output 1: one-cycle completion pulse.
- `busy` output 1: high from cycle after acceptance until ready cycle inclusive.
- `err` output 1: misaligned-access flag, valid with `ready` (see Configuration).

## Operation
- States: IDLE, WAIT, RESP.
- IDLE: `req`=1 latches `DataMemRW`, `addr`, `wdata`; wait counter loaded with `WAIT_CYCLES`. Next state WAIT if `WAIT_CYCLES`>0, else RESP.
- WAIT: counter decrements each cycle; at counter==1 → RESP. Inputs ignored.
- RESP: access performed on this edge; `ready`=1 for this cycle only; next state IDLE. `req` in RESP ignored (no back-to-back acceptance; next request taken earliest the cycle after `ready`).
- Index = latched `addr[log2(DEPTH_BYTES)-1:0]` with bits [1:0] forced 0; upper address bits ignored (wrap modulo DEPTH_BYTES).
- Big-endian: byte[i] = bits 31:24, byte[i+1] = 23:16, byte[i+2] = 15:8, byte[i+3] = 7:0.
- Write: all four bytes updated at RESP edge; `rdata` unchanged.
- Read: `rdata` loaded at RESP edge, held until next completed read.
- Memory array is not reset; initial contents undefined (bench preloads).

## Timing
- Request sampled at edge N (IDLE, `req`=1) → `ready` high during cycle N+WAIT_CYCLES+1; `rdata` valid from same cycle.
- `busy` high cycles N+1 … N+WAIT_CYCLES+1.
- Reset values: `rdata`=0, `ready`=0, `busy`=0, `err`=0, state IDLE, counter 0.
- Reset mid-operation (WAIT or RESP edge with `RST`=0): request aborted, no write, `rdata` stays 0; reset wins over access on same edge.
- `req` held high continuously: re-accepted every WAIT_CYCLES+2 cycles.

## Configuration
- `DMEM_ALIGN_CHECK_EN` defined: if latched `addr[1:0]`≠0, RESP cycle pulses `ready` with `err`=1, write suppressed, `rdata` unchanged; `err`=0 on aligned completions and outside `ready` cycles.
- Undefined: `err` tied 0; `addr[1:0]` silently ignored (access forced word-aligned).

## Test plan
- Reset: hold `RST`=0 two cycles → `rdata`=0, `ready`=0, `busy`=0, `err`=0.
- Store then load, WAIT_CYCLES=1: write 0x12345678 to addr 0x10 → `ready` 2 cycles after acceptance; read 0x10 → `rdata`=0x12345678; byte[0x10]=0x12, byte[0x13]=0x78.
- WAIT_CYCLES=0 and =3: read latency 1 and 4 cycles; `busy` width 1 and 4; `req` pulses during busy produce no extra `ready`.
- Wrap: DEPTH_BYTES=128, write 0xDEADBEEF to 0x84 → read 0x04 returns 0xDEADBEEF.
- Reset mid-op: write 0xCAFEF00D to 0x20, drop `RST` in WAIT → no `ready`; subsequent read of 0x20 returns prior preload value.
- Misaligned addr 0x22 write 0xFFFFFFFF: with `DMEM_ALIGN_CHECK_EN` → `ready`+`err`=1, word 0x20 unchanged; without → `err`=0, word 0x20 = 0xFFFFFFFF.

Source files
------------

// File: rtl/data_mem_responder.sv
// data_mem_responder: multicycle slave for load/store requests on a
// byte-addressed, big-endian data memory. One request at a time, a fixed
// number of wait states, then a one-cycle ready pulse with registered results.
// Optional feature macro: DMEM_ALIGN_CHECK_EN -- when defined, a request whose
// address is not word aligned completes with err=1 and has no effect on the
// memory or rdata; when undefined, err is tied low and addr[1:0] are ignored.
module data_mem_responder #(
    parameter int DEPTH_BYTES = 128,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        RST,
    input  logic        req,
    input  logic        DataMemRW,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        busy,
    output logic        err
);
    localparam int AW = $clog2(DEPTH_BYTES);
    localparam int WW = AW - 2;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t        state_reg, state_next;
    logic [3:0]    cnt_reg, cnt_next;
    logic          accept;
    logic          access;
    logic          allowed;

    logic          wr_reg;
    logic [WW-1:0] word_reg;
    logic [31:0]   wdata_reg;

    logic [7:0]    mem [DEPTH_BYTES];
    logic [31:0]   rd_word;

    logic [31:0]   rdata_reg;
    logic          ready_reg;
    logic          busy_reg;

    // Next-state and wait-counter logic; requests only accepted in IDLE.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        accept     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (req) begin
                    accept     = 1'b1;
                    cnt_next   = 4'(WAIT_CYCLES);
                    state_next = (WAIT_CYCLES > 0) ? WAIT : RESP;
                end
            end
            WAIT: begin
                cnt_next = cnt_reg - 4'd1;
                if (cnt_reg == 4'd1) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and wait-counter registers.
    always_ff @(posedge clk) begin
        if (!RST) begin
            state_reg <= IDLE;
            cnt_reg   <= 4'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // The access happens on the edge that leaves RESP.
    assign access = (state_reg == RESP);

`ifdef DMEM_ALIGN_CHECK_EN
    logic misalign_reg;
    logic err_reg;
    logic unused_addr;

    assign unused_addr = ^addr[31:AW];
    assign allowed     = !misalign_reg;
    assign err         = err_reg;

    // Misalignment flag captured at acceptance, reported alongside ready.
    always_ff @(posedge clk) begin
        if (!RST) begin
            misalign_reg <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            if (accept) begin
                misalign_reg <= |addr[1:0];
            end
            err_reg <= access && misalign_reg;
        end
    end
`else
    logic unused_addr;

    // Low address bits are dropped: every access is forced word aligned.
    assign unused_addr = ^{addr[31:AW], addr[1:0]};
    assign allowed     = 1'b1;
    assign err         = 1'b0;
`endif

    // Request fields latched at acceptance; inputs are ignored afterwards.
    always_ff @(posedge clk) begin
        if (!RST) begin
            wr_reg    <= 1'b0;
            word_reg  <= '0;
            wdata_reg <= 32'd0;
        end else if (accept) begin
            wr_reg    <= DataMemRW;
            word_reg  <= addr[AW-1:2];
            wdata_reg <= wdata;
        end
    end

    // Big-endian word assembly: lowest byte address carries bits 31:24.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign rd_word[31-8*gi -: 8] = mem[{word_reg, 2'(gi)}];
    end

    // Store of all four bytes; reset on the same edge cancels the access.
    always_ff @(posedge clk) begin
        if (RST && access && wr_reg && allowed) begin
            for (int b = 0; b < 4; b++) begin
                mem[{word_reg, 2'(b)}] <= wdata_reg[31-8*b -: 8];
            end
        end
    end

    // Registered completion pulse, busy window and load data.
    always_ff @(posedge clk) begin
        if (!RST) begin
            rdata_reg <= 32'd0;
            ready_reg <= 1'b0;
            busy_reg  <= 1'b0;
        end else begin
            ready_reg <= access;
            busy_reg  <= (state_reg != IDLE);
            if (access && !wr_reg && allowed) begin
                rdata_reg <= rd_word;
            end
        end
    end

    assign rdata = rdata_reg;
    assign ready = ready_reg;
    assign busy  = busy_reg;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: three instances (WAIT_CYCLES 1, 0, 3)
// share a clock; stimulus pushes expected responses, a monitor pops on ready.
module tb_data_mem_responder;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_v   [3];
    logic        req_v   [3];
    logic        rw_v    [3];
    logic [31:0] addr_v  [3];
    logic [31:0] wdata_v [3];
    logic [31:0] rdata_v [3];
    logic        ready_v [3];
    logic        busy_v  [3];
    logic        err_v   [3];

    data_mem_responder #(.DEPTH_BYTES(128), .WAIT_CYCLES(1)) u_w1 (
        .clk(clk), .RST(rst_v[0]), .req(req_v[0]), .DataMemRW(rw_v[0]),
        .addr(addr_v[0]), .wdata(wdata_v[0]), .rdata(rdata_v[0]),
        .ready(ready_v[0]), .busy(busy_v[0]), .err(err_v[0]));

    data_mem_responder #(.DEPTH_BYTES(128), .WAIT_CYCLES(0)) u_w0 (
        .clk(clk), .RST(rst_v[1]), .req(req_v[1]), .DataMemRW(rw_v[1]),
        .addr(addr_v[1]), .wdata(wdata_v[1]), .rdata(rdata_v[1]),
        .ready(ready_v[1]), .busy(busy_v[1]), .err(err_v[1]));

    data_mem_responder #(.DEPTH_BYTES(128), .WAIT_CYCLES(3)) u_w3 (
        .clk(clk), .RST(rst_v[2]), .req(req_v[2]), .DataMemRW(rw_v[2]),
        .addr(addr_v[2]), .wdata(wdata_v[2]), .rdata(rdata_v[2]),
        .ready(ready_v[2]), .busy(busy_v[2]), .err(err_v[2]));

    typedef struct {
        int          inst;
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t        exp_q[$];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] last_rd [3];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int wc_of(int k);
        return (k == 0) ? 1 : ((k == 1) ? 0 : 3);
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, expv);
        end
    endtask

    // Pops one expectation per ready pulse and compares instance, cycle, data, err.
    task automatic scoreboard_monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                if (ready_v[k] === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_ready inst%0d: got ready=1 at cycle %0d required no response", k, cyc);
                    end else begin
                        e = exp_q.pop_front();
                        check($sformatf("resp_inst cyc%0d", cyc), 32'(k), 32'(e.inst));
                        check($sformatf("resp_cycle inst%0d", k), 32'(cyc), 32'(e.cyc));
                        check($sformatf("resp_rdata inst%0d", k), rdata_v[k], e.rdata);
                        check($sformatf("resp_err inst%0d", k), 32'(err_v[k]), 32'(e.err));
                    end
                end
            end
        end
    endtask

    // One transaction; optional req pulses while the DUT is busy; checks busy width.
    task automatic do_op(int k, logic rw, logic [31:0] a, logic [31:0] wd,
                         logic [31:0] exp_rd, logic exp_err, bit pulse);
        exp_t e;
        int   width;
        bit   seen;
        @(negedge clk);
        req_v[k] = 1'b1; rw_v[k] = rw; addr_v[k] = a; wdata_v[k] = wd;
        @(posedge clk);
        #1;
        e.inst = k; e.rdata = exp_rd; e.err = exp_err; e.cyc = cyc + wc_of(k) + 1;
        exp_q.push_back(e);
        $display("txn inst%0d %s addr=%08h wdata=%08h exp_rdata=%08h exp_err=%0b accept_cyc=%0d",
                 k, rw ? "WR" : "RD", a, wd, exp_rd, exp_err, cyc);
        req_v[k] = pulse; rw_v[k] = ~rw; addr_v[k] = 32'h0; wdata_v[k] = 32'hFFFF_FFFF;
        width = 0; seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (busy_v[k] === 1'b1) begin
                width++;
                seen = 1'b1;
            end else if (seen) begin
                break;
            end
            req_v[k] = pulse && busy_v[k] && !ready_v[k];
        end
        req_v[k] = 1'b0;
        check($sformatf("busy_width inst%0d", k), 32'(width), 32'(wc_of(k) + 1));
    endtask

    task automatic wr(int k, logic [31:0] a, logic [31:0] d, logic exp_err, bit pulse);
        do_op(k, 1'b1, a, d, last_rd[k], exp_err, pulse);
    endtask

    task automatic rd(int k, logic [31:0] a, logic [31:0] expv, bit pulse);
        do_op(k, 1'b0, a, 32'h0, expv, 1'b0, pulse);
        last_rd[k] = expv;
    endtask

    // Accept a store, then reset after 'skip' negedges for 'hold' cycles.
    task automatic abort_op(int k, logic [31:0] a, logic [31:0] d, int skip, int hold);
        @(negedge clk);
        req_v[k] = 1'b1; rw_v[k] = 1'b1; addr_v[k] = a; wdata_v[k] = d;
        @(posedge clk);
        #1;
        req_v[k] = 1'b0;
        $display("txn inst%0d ABORT addr=%08h wdata=%08h accept_cyc=%0d", k, a, d, cyc);
        repeat (skip + 1) @(negedge clk);
        rst_v[k] = 1'b0;
        repeat (hold) @(negedge clk);
        rst_v[k] = 1'b1;
        repeat (6) @(negedge clk);
        check($sformatf("abort_busy inst%0d", k), 32'(busy_v[k]), 32'd0);
        check($sformatf("abort_rdata inst%0d", k), rdata_v[k], 32'd0);
        last_rd[k] = 32'd0;
    endtask

    initial begin
        exp_t e;
        for (int k = 0; k < 3; k++) begin
            rst_v[k] = 1'b0; req_v[k] = 1'b0; rw_v[k] = 1'b0;
            addr_v[k] = 32'h0; wdata_v[k] = 32'h0; last_rd[k] = 32'h0;
        end
        fork
            scoreboard_monitor();
        join_none

        // Reset held for two edges.
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("reset_rdata inst%0d", k), rdata_v[k], 32'd0);
            check($sformatf("reset_ready inst%0d", k), 32'(ready_v[k]), 32'd0);
            check($sformatf("reset_busy inst%0d", k), 32'(busy_v[k]), 32'd0);
            check($sformatf("reset_err inst%0d", k), 32'(err_v[k]), 32'd0);
            rst_v[k] = 1'b1;
        end

        // Store/load on WAIT_CYCLES=1, with big-endian byte placement.
        wr(0, 32'h10, 32'h1234_5678, 1'b0, 1'b1);
        check("byte_0x10", 32'(u_w1.mem[16]), 32'h12);
        check("byte_0x13", 32'(u_w1.mem[19]), 32'h78);
        rd(0, 32'h10, 32'h1234_5678, 1'b1);

        // WAIT_CYCLES=0 and 3 with req pulses during busy.
        wr(1, 32'h08, 32'hA5A5_A5A5, 1'b0, 1'b1);
        rd(1, 32'h08, 32'hA5A5_A5A5, 1'b1);
        wr(2, 32'h3C, 32'h0BAD_F00D, 1'b0, 1'b1);
        rd(2, 32'h3C, 32'h0BAD_F00D, 1'b1);

        // req held high on WAIT_CYCLES=0: accepted every 2 cycles.
        @(negedge clk);
        req_v[1] = 1'b1; rw_v[1] = 1'b0; addr_v[1] = 32'h08;
        @(posedge clk);
        #1;
        for (int j = 0; j < 3; j++) begin
            e.inst = 1; e.rdata = 32'hA5A5_A5A5; e.err = 1'b0; e.cyc = cyc + 1 + 2 * j;
            exp_q.push_back(e);
            $display("txn inst1 RD held addr=00000008 exp_rdata=a5a5a5a5 exp_cyc=%0d", e.cyc);
        end
        repeat (5) @(negedge clk);
        req_v[1] = 1'b0;
        repeat (4) @(negedge clk);

        // Address wrap modulo 128 bytes; upper bits ignored.
        wr(0, 32'h84, 32'hDEAD_BEEF, 1'b0, 1'b0);
        rd(0, 32'h04, 32'hDEAD_BEEF, 1'b0);
        rd(0, 32'hFFFF_FF84, 32'hDEAD_BEEF, 1'b0);

        // Reset during WAIT (WAIT_CYCLES=3) and exactly on the RESP edge (WAIT_CYCLES=1).
        wr(2, 32'h20, 32'h1122_3344, 1'b0, 1'b0);
        abort_op(2, 32'h20, 32'hCAFE_F00D, 0, 2);
        rd(2, 32'h20, 32'h1122_3344, 1'b0);
        wr(0, 32'h20, 32'h5566_7788, 1'b0, 1'b0);
        abort_op(0, 32'h20, 32'hCAFE_F00D, 1, 1);
        rd(0, 32'h20, 32'h5566_7788, 1'b0);

        // Misaligned accesses.
`ifdef DMEM_ALIGN_CHECK_EN
        wr(0, 32'h22, 32'hFFFF_FFFF, 1'b1, 1'b0);
        do_op(0, 1'b0, 32'h21, 32'h0, last_rd[0], 1'b1, 1'b0);
        wr(0, 32'h24, 32'h0102_0304, 1'b0, 1'b0);
        rd(0, 32'h20, 32'h5566_7788, 1'b0);
`else
        wr(0, 32'h22, 32'hFFFF_FFFF, 1'b0, 1'b0);
        rd(0, 32'h20, 32'hFFFF_FFFF, 1'b0);
        rd(0, 32'h23, 32'hFFFF_FFFF, 1'b0);
`endif

        repeat (8) @(negedge clk);
        check("pending_responses", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no completion within 200000 time units required finish");
        $fatal(1, "timeout");
    end

endmodule
